// File: rtl/sqrt_request_arbiter.sv
// Round-robin front end sharing one FP16 square-root core among N_REQ requesters.
// Define SQRT_ARB_SPECIAL_BYPASS_EN to answer NaN/inf/zero/negative operands without the core.
module sqrt_request_arbiter #(
  parameter int unsigned N_REQ = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [16*N_REQ-1:0]  req_data,
  output logic [N_REQ-1:0]     req_ready,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [1:0]           rsp_id,
  output logic [15:0]          rsp_data,
  output logic                 core_start,
  output logic [15:0]          core_operand,
  input  logic                 core_valid,
  input  logic [15:0]          core_result,
  output logic                 busy
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StRespond} state_e;

  state_e      r_state, w_state_next;
  logic [1:0]  r_rr_ptr, r_id;
  logic [15:0] r_operand, r_rsp_data;

  logic        w_hi_found, w_grant_found, w_accept, w_special;
  logic [1:0]  w_hi_idx, w_lo_idx, w_grant_idx, w_ptr_next;
  logic [15:0] w_grant_data, w_special_data;

  // Lowest valid index at or above the pointer wins; otherwise wrap to the lowest valid index.
  always_comb begin
    w_hi_found = 1'b0;
    w_hi_idx   = 2'd0;
    w_lo_idx   = 2'd0;
    for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        w_lo_idx = 2'(i);
        if (2'(i) >= r_rr_ptr) begin
          w_hi_found = 1'b1;
          w_hi_idx   = 2'(i);
        end
      end
    end
    w_grant_found = |req_valid;
    w_grant_idx   = w_hi_found ? w_hi_idx : w_lo_idx;
  end

  always_comb begin
    w_grant_data = 16'h0000;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (w_grant_idx == 2'(i)) w_grant_data = req_data[16*i +: 16];
    end
  end

`ifdef SQRT_ARB_SPECIAL_BYPASS_EN
  always_comb begin
    w_special      = 1'b1;
    w_special_data = 16'h7E00;
    if (w_grant_data[14:10] == 5'h1f && w_grant_data[9:0] != 10'd0) begin
      w_special_data = 16'h7E00;
    end else if (w_grant_data[14:0] == 15'd0) begin
      // sqrt(+0)=+0 and sqrt(-0)=-0
      w_special_data = w_grant_data;
    end else if (w_grant_data[15]) begin
      w_special_data = 16'h7E00;
    end else if (w_grant_data[14:10] == 5'h1f) begin
      w_special_data = 16'h7C00;
    end else begin
      w_special = 1'b0;
    end
  end
`else
  assign w_special      = 1'b0;
  assign w_special_data = 16'h0000;
`endif

  assign w_ptr_next = (r_id == 2'(N_REQ - 1)) ? 2'd0 : r_id + 2'd1;

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    req_ready    = '0;
    core_start   = 1'b0;
    rsp_valid    = 1'b0;
    unique case (r_state)
      StIdle: begin
        // No accept pulse while reset is asserted: the grant would be discarded.
        if (w_grant_found && !rst) begin
          w_accept     = 1'b1;
          req_ready    = {{(N_REQ-1){1'b0}}, 1'b1} << w_grant_idx;
          w_state_next = w_special ? StRespond : StIssue;
        end
      end
      StIssue: begin
        core_start   = 1'b1;
        w_state_next = StWait;
      end
      StWait: begin
        if (core_valid) w_state_next = StRespond;
      end
      StRespond: begin
        rsp_valid = 1'b1;
        if (rsp_ready) w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= StIdle;
      r_rr_ptr   <= 2'd0;
      r_id       <= 2'd0;
      r_operand  <= 16'h0000;
      r_rsp_data <= 16'h0000;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_id      <= w_grant_idx;
        r_operand <= w_grant_data;
        if (w_special) r_rsp_data <= w_special_data;
      end
      if (r_state == StWait && core_valid) r_rsp_data <= core_result;
      if (r_state == StRespond && rsp_ready) r_rr_ptr <= w_ptr_next;
    end
  end

  assign rsp_id       = r_id;
  assign rsp_data     = r_rsp_data;
  assign core_operand = r_operand;
  assign busy         = (r_state != StIdle);

endmodule

// File: tb/tb_sqrt_request_arbiter.sv
// Self-checking bench for sqrt_request_arbiter: vector table, corner sequences, random traffic.
module tb_sqrt_request_arbiter;

`ifdef SQRT_ARB_SPECIAL_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [63:0] req_data;
  logic [3:0]  req_ready;
  logic        rsp_valid, rsp_ready;
  logic [1:0]  rsp_id;
  logic [15:0] rsp_data;
  logic        core_start;
  logic [15:0] core_operand;
  logic        core_valid;
  logic [15:0] core_result;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;
  int m_ptr = 0;

  always #5 clk = ~clk;

  sqrt_request_arbiter #(.N_REQ(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_id       (rsp_id),
    .rsp_data     (rsp_data),
    .core_start   (core_start),
    .core_operand (core_operand),
    .core_valid   (core_valid),
    .core_result  (core_result),
    .busy         (busy)
  );

  typedef struct {
    logic [3:0]  mask;
    int          exp_id;
    int          lat;
    logic [15:0] res;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  function automatic bit is_nan(input logic [15:0] x);
    return (x[14:10] == 5'h1f) && (x[9:0] != 10'd0);
  endfunction

  function automatic bit is_special(input logic [15:0] x);
    return is_nan(x) || x[15] || (x == 16'h7C00) || (x[14:0] == 15'd0);
  endfunction

  function automatic logic [15:0] special_map(input logic [15:0] x);
    if (is_nan(x)) return 16'h7E00;
    if (x == 16'h0000) return 16'h0000;
    if (x == 16'h8000) return 16'h8000;
    if (x[15]) return 16'h7E00;
    if (x == 16'h7C00) return 16'h7C00;
    return x;
  endfunction

  function automatic logic [15:0] rand_op();
    if ($urandom_range(0, 3) != 0) return 16'($urandom);
    case ($urandom_range(0, 5))
      0: return 16'h7E01;
      1: return 16'h7C00;
      2: return 16'h0000;
      3: return 16'h8000;
      4: return 16'hFC00;
      default: return 16'hC400;
    endcase
  endfunction

  function automatic int model_grant(input logic [3:0] mask, input int ptr);
    for (int k = 0; k < 4; k++) begin
      if (mask[(ptr + k) % 4]) return (ptr + k) % 4;
    end
    return -1;
  endfunction

  // One complete transaction starting at an idle cycle; ends on the cycle after the handshake.
  task automatic txn(input string nm, input logic [3:0] mask, input int exp_id, input int lat,
                     input logic [15:0] res, input int hold, input bit junk);
    logic [15:0] op, exp_data;
    bit          via_core;
    op       = 16'(req_data >> (16 * exp_id));
    via_core = !(BYP && is_special(op));
    exp_data = via_core ? res : special_map(op);
    req_valid = mask;
    #1;
    chk({nm, ":accept_ready"}, 32'(req_ready), 32'(4'b0001 << exp_id));
    chk({nm, ":accept_busy"}, 32'(busy), 32'd0);
    chk({nm, ":accept_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({nm, ":accept_start"}, 32'(core_start), 32'd0);
    @(negedge clk);
    if (via_core) begin
      core_valid  = junk;
      core_result = 16'hDEAD;
      #1;
      chk({nm, ":issue_start"}, 32'(core_start), 32'd1);
      chk({nm, ":issue_operand"}, 32'(core_operand), 32'(op));
      chk({nm, ":issue_ready"}, 32'(req_ready), 32'd0);
      @(negedge clk);
      core_valid = 1'b0;
      for (int i = 0; i < lat; i++) begin
        #1;
        chk({nm, ":wait_quiet"}, 32'({rsp_valid, core_start, req_ready}), 32'd0);
        @(negedge clk);
      end
      core_valid  = 1'b1;
      core_result = res;
      #1;
      chk({nm, ":wait_rsp_valid"}, 32'(rsp_valid), 32'd0);
      @(negedge clk);
      core_valid = 1'b0;
    end
    for (int i = 0; i <= hold; i++) begin
      rsp_ready   = (i == hold);
      core_valid  = junk;
      core_result = 16'hBEEF;
      #1;
      chk({nm, ":rsp_valid"}, 32'(rsp_valid), 32'd1);
      chk({nm, ":rsp_id"}, 32'(rsp_id), 32'(exp_id));
      chk({nm, ":rsp_data"}, 32'(rsp_data), 32'(exp_data));
      chk({nm, ":rsp_quiet"}, 32'({req_ready, core_start}), 32'd0);
      @(negedge clk);
    end
    rsp_ready  = 1'b0;
    core_valid = 1'b0;
    req_valid  = 4'b0000;
    m_ptr      = (exp_id + 1) % 4;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = 4'b0000;
    @(negedge clk);
    rst   = 1'b0;
    m_ptr = 0;
  endtask

  vec_t tbl[9];
  int   rr_exp[5];

  initial begin
    tbl[0] = '{4'b0001, 0, 1, 16'h1001};
    tbl[1] = '{4'b0001, 0, 0, 16'h1002};
    tbl[2] = '{4'b1010, 1, 2, 16'h1003};
    tbl[3] = '{4'b1010, 3, 1, 16'h1004};
    tbl[4] = '{4'b0110, 1, 3, 16'h1005};
    tbl[5] = '{4'b0101, 2, 0, 16'h1006};
    tbl[6] = '{4'b1111, 3, 2, 16'h1007};
    tbl[7] = '{4'b1100, 2, 1, 16'h1008};
    tbl[8] = '{4'b0011, 0, 4, 16'h1009};
    rr_exp = '{0, 1, 2, 3, 0};

    // Reset with requests pending: nothing may be accepted.
    rst = 1'b1; req_valid = 4'hF; req_data = 64'h3C00_3C00_3C00_3C00;
    rsp_ready = 1'b0; core_valid = 1'b0; core_result = 16'h0000;
    @(negedge clk); @(negedge clk);
    #1;
    chk("reset:req_ready", 32'(req_ready), 32'd0);
    chk("reset:outputs",
        32'({busy, rsp_valid, core_start, rsp_id, rsp_data == 16'h0, core_operand == 16'h0}),
        32'b0000011);
    @(negedge clk);
    rst = 1'b0; req_valid = 4'h0;
    #1;
    chk("reset:busy_after", 32'(busy), 32'd0);
    @(negedge clk);

    // Single request with a long core latency.
    req_data = 64'h0000_0000_4400_0000;
    txn("single", 4'b0010, 1, 11, 16'h4000, 0, 1'b0);

    do_reset();
    req_data = 64'h3C03_3C02_3C01_3C00;
    for (int v = 0; v < 9; v++) begin
      txn($sformatf("tbl%0d", v), tbl[v].mask, tbl[v].exp_id, tbl[v].lat, tbl[v].res, 0, 1'b0);
    end

    // Backpressure: five stalled RESPOND cycles before the handshake.
    txn("backpressure", 4'b0001, 0, 2, 16'h2345, 5, 1'b1);

    req_data = 64'h0000_FC00_0000_0000;
    txn("neg_inf", 4'b0100, 2, 1, 16'h1234, 0, 1'b0);

    // Reset two cycles after core_start, late core_valid must be ignored.
    req_data  = 64'h4000_0000_0000_0000;
    req_valid = 4'b1000;
    #1;
    chk("rstwait:accept", 32'(req_ready), 32'b1000);
    @(negedge clk);
    req_valid = 4'b0000;
    #1;
    chk("rstwait:start", 32'(core_start), 32'd1);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rstwait:cleared",
        32'({busy, rsp_valid, core_start, rsp_id, rsp_data, core_operand}), 32'd0);
    repeat (3) @(negedge clk);
    core_valid = 1'b1; core_result = 16'h5555;
    @(negedge clk);
    core_valid = 1'b0;
    #1;
    chk("rstwait:late_valid", 32'({busy, rsp_valid}), 32'd0);
    @(negedge clk);
    m_ptr = 0;

    // Round robin with all four requesters held high.
    req_data = 64'h3C03_3C02_3C01_3C00;
    for (int g = 0; g < 5; g++) begin
      txn($sformatf("rr%0d", g), 4'b1111, rr_exp[g], 2, 16'(16'h2000 + g), 0, 1'b0);
    end

    // Random traffic against the arbitration and special-value model.
    for (int t = 0; t < 150; t++) begin
      logic [3:0] mask;
      mask     = 4'($urandom);
      req_data = {rand_op(), rand_op(), rand_op(), rand_op()};
      if (mask == 4'b0000) begin
        req_valid = 4'b0000;
        #1;
        chk("rnd:idle", 32'({req_ready, busy, rsp_valid}), 32'd0);
        @(negedge clk);
        continue;
      end
      txn($sformatf("rnd%0d", t), mask, model_grant(mask, m_ptr), $urandom_range(0, 4),
          16'($urandom), $urandom_range(0, 3), 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sqrt_request_arbiter.md
SQRT_REQUEST_ARBITER -- requirements
Module: sqrt_request_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4, meaning number of requesters sharing one FP16 sqrt core; legal range 2..4.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port req_valid  input  N_REQ  per-requester operand-valid.
REQ-005 SHALL have port req_data  input  16*N_REQ  FP16 operands; requester i at bits [16i+15:16i].
REQ-006 SHALL have port req_ready  output  N_REQ  one-hot accept pulse to the granted requester.
REQ-007 SHALL have port rsp_valid  output  1  result available on shared response bus.
REQ-008 SHALL have port rsp_ready  input  1  response consumer accepts.
REQ-009 SHALL have port rsp_id  output  2  index of requester owning rsp_data.
REQ-010 SHALL have port rsp_data  output  16  FP16 square-root result.
REQ-011 SHALL have port core_start  output  1  one-cycle start pulse to the sqrt core.
REQ-012 SHALL have port core_operand  output  16  latched operand driven to the core, stable from start until core_valid.
REQ-013 SHALL have port core_valid  input  1  core result-valid pulse.
REQ-014 SHALL have port core_result  input  16  core result, sampled when core_valid=1.
REQ-015 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-016 SHALL implement states IDLE, ISSUE, WAIT, RESPOND.
REQ-017 IDLE: if any req_valid, SHALL grant the first valid index at or after rr_ptr (modulo N_REQ), assert req_ready for that index in the same cycle, latch operand and id, go to ISSUE.
REQ-018 IDLE with no req_valid: SHALL remain in IDLE with all req_ready=0.
REQ-019 ISSUE: SHALL assert core_start for exactly one cycle, then go to WAIT.
REQ-020 WAIT: on core_valid=1 SHALL latch core_result into rsp_data and go to RESPOND; otherwise SHALL remain in WAIT indefinitely.
REQ-021 core_valid in any state other than WAIT SHALL be ignored.
REQ-022 RESPOND: SHALL hold rsp_valid=1 and stable rsp_id/rsp_data until rsp_ready=1; on that handshake cycle SHALL set rr_ptr to (granted id + 1) mod N_REQ and go to IDLE.
REQ-023 Minimum latency SHALL be: accept at cycle T, core_start at T+1, rsp_valid at the cycle after core_valid.
REQ-024 Only one request SHALL be in flight; req_ready SHALL be 0 in all states except IDLE.
REQ-025 A new grant SHALL NOT occur in the same cycle as the RESPOND handshake; next accept is earliest one cycle later.
REQ-026 req_valid deasserted before grant SHALL be treated as withdrawn; no obligation to serve it.

Reset
REQ-027 On rst=1 SHALL enter IDLE, set rr_ptr=0, and clear req_ready, rsp_valid, rsp_id, rsp_data, core_start, core_operand, busy to 0 on the next edge.
REQ-028 Reset in any state, including mid-WAIT, SHALL abandon the in-flight request without response; any later core_valid SHALL be ignored unless in WAIT.
REQ-029 rst SHALL take priority over every other input in the same cycle.

Configuration
REQ-030 Macro SQRT_ARB_SPECIAL_BYPASS_EN SHALL compile in special-value bypass.
REQ-031 With the macro defined, an accepted operand that is NaN, +inf, +/-0, or negative nonzero SHALL skip ISSUE/WAIT and go straight to RESPOND with rsp_data: NaN->0x7E00, +inf->0x7C00, +0->0x0000, -0->0x8000, negative nonzero (including -inf)->0x7E00; core_start SHALL stay 0.
REQ-032 Without the macro, every accepted operand SHALL go through ISSUE/WAIT to the core.

Verification
REQ-033 Single request: req_valid[1]=1, data 0x4400 (4.0), core returns 0x4000 after 12 cycles -> one req_ready[1] pulse, one core_start pulse, rsp_valid with rsp_id=1 and rsp_data=0x4000.
REQ-034 Round robin: all four req_valid held high, each core result returned after 3 cycles, rsp_ready=1 -> grant order 0,1,2,3,0, with exactly one core_start per grant.
REQ-035 Backpressure: rsp_ready=0 for 5 cycles in RESPOND -> rsp_valid/rsp_id/rsp_data stable for those cycles, req_ready all 0, then release on the handshake.
REQ-036 Reset mid-WAIT: rst pulsed 2 cycles after core_start, core_valid arrives 4 cycles later -> no rsp_valid, busy=0, next grant starts from index 0.
REQ-037 Bypass (macro on): operand 0xFC00 (-inf) -> rsp_valid the cycle after accept with rsp_data=0x7E00 and no core_start; with the macro off, the same stimulus produces a core_start pulse.
